// File: rtl/div_sign_ctrl.sv
// rtl/div_sign_ctrl.sv - operand FIFO, start/capture sequencer and watchdog for div_sign
// Divide-by-zero is answered locally; everything else runs through the external divider.
module div_sign_ctrl #(
  parameter int Q      = 15,
  parameter int N      = 32,
  parameter int DEPTH  = 4,
  parameter int TO_CYC = 64
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_dividend,
  input  logic [N-1:0] s_divisor,
  input  logic         s_both_image,
  output logic         o_div_start,
  output logic [N-1:0] o_div_dividend,
  output logic [N-1:0] o_div_divisor,
  output logic         o_div_both_image,
  input  logic         i_div_complete,
  input  logic [N-1:0] i_div_quotient,
  input  logic         i_div_overflow,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_quotient,
  output logic         m_overflow,
  output logic         m_div0,
  output logic         m_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TO_CYC + 1);
  localparam int FW = 2 * N + 1;
  localparam logic [WW-1:0] TO_LIM = WW'(TO_CYC);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_ARM, S_WAIT} state_t;

  state_t        state, state_n;
  logic [FW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [WW-1:0] wdog;

  logic         push, pop, fifo_empty, fifo_full, slot_free;
  logic [N-1:0] head_dividend, head_divisor;
  logic         head_both_image, head_div0, head_sign;
  logic         wr_div0, wr_cap, wr_to;

  // Q only describes the divider's number format; the sequencing does not depend on it.
  logic unused_q;
  assign unused_q = ^Q;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready;
  assign slot_free  = !m_valid || m_ready;

  assign {head_dividend, head_divisor, head_both_image} = fifo_mem[rd_ptr];
  assign head_div0  = (head_divisor[N-2:0] == '0);
  assign head_sign  = head_dividend[N-1] ^ head_divisor[N-1] ^ head_both_image;

  assign o_div_start = (state == S_START);

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {s_dividend, s_divisor, s_both_image};
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    wr_div0 = 1'b0;
    wr_cap  = 1'b0;
    wr_to   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (head_div0) begin
            // A zero divisor waits in the FIFO until its result has somewhere to go.
            if (slot_free) begin
              pop     = 1'b1;
              wr_div0 = 1'b1;
            end
          end else begin
            pop     = 1'b1;
            state_n = S_START;
          end
        end
      end
      S_START: state_n = S_ARM;
      // complete may still be high from the previous operation here.
      S_ARM:   state_n = S_WAIT;
      S_WAIT: begin
        if (i_div_complete) begin
          if (slot_free) begin
            wr_cap  = 1'b1;
            state_n = S_IDLE;
          end
        end else if (wdog == TO_LIM) begin
          if (slot_free) begin
            wr_to   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state            <= S_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      wdog             <= '0;
      o_div_dividend   <= '0;
      o_div_divisor    <= '0;
      o_div_both_image <= 1'b0;
      m_valid          <= 1'b0;
      m_quotient       <= '0;
      m_overflow       <= 1'b0;
      m_div0           <= 1'b0;
      m_timeout        <= 1'b0;
    end else begin
      state <= state_n;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);

      // Operands stay put from pop until capture: the divider's sign output follows them.
      if (pop) begin
        o_div_dividend   <= head_dividend;
        o_div_divisor    <= head_divisor;
        o_div_both_image <= head_both_image;
      end

      if (state == S_START) begin
        wdog <= '0;
      end else if (state == S_WAIT && !i_div_complete && wdog != TO_LIM) begin
        wdog <= wdog + 1'b1;
      end

      if (wr_div0) begin
        m_valid    <= 1'b1;
        m_quotient <= head_sign ? {1'b1, {(N-2){1'b0}}, 1'b1} : {1'b0, {(N-1){1'b1}}};
        m_overflow <= 1'b1;
        m_div0     <= 1'b1;
        m_timeout  <= 1'b0;
      end else if (wr_cap) begin
        m_valid    <= 1'b1;
        m_quotient <= i_div_quotient;
        m_overflow <= i_div_overflow;
        m_div0     <= 1'b0;
        m_timeout  <= 1'b0;
      end else if (wr_to) begin
        m_valid    <= 1'b1;
        m_quotient <= '0;
        m_overflow <= 1'b1;
        m_div0     <= 1'b0;
        m_timeout  <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// tb/tb_div_sign_ctrl.sv - self-checking bench for div_sign_ctrl with a behavioural divider stub
module tb_div_sign_ctrl;
  localparam int N = 32;
  localparam int Q = 15;
  localparam int DEPTH = 4;
  localparam int TO_CYC = 64;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [N-1:0]  s_dividend = '0;
  logic [N-1:0]  s_divisor = '0;
  logic          s_both_image = 1'b0;
  logic          o_div_start;
  logic [N-1:0]  o_div_dividend;
  logic [N-1:0]  o_div_divisor;
  logic          o_div_both_image;
  logic          i_div_complete = 1'b0;
  logic [N-1:0]  i_div_quotient;
  logic          i_div_overflow;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [N-1:0]  m_quotient;
  logic          m_overflow;
  logic          m_div0;
  logic          m_timeout;

  div_sign_ctrl #(.Q(Q), .N(N), .DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_dividend(s_dividend),
    .s_divisor(s_divisor), .s_both_image(s_both_image),
    .o_div_start(o_div_start), .o_div_dividend(o_div_dividend),
    .o_div_divisor(o_div_divisor), .o_div_both_image(o_div_both_image),
    .i_div_complete(i_div_complete), .i_div_quotient(i_div_quotient),
    .i_div_overflow(i_div_overflow),
    .m_valid(m_valid), .m_ready(m_ready), .m_quotient(m_quotient),
    .m_overflow(m_overflow), .m_div0(m_div0), .m_timeout(m_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] q; logic ovf; logic div0; logic to; } res_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic bi; logic to; } op_t;
  typedef struct {
    logic [31:0] a; logic [31:0] b; logic bi;
    logic [31:0] q; logic ovf; logic div0; int starts;
  } vec_t;

  int n_checks = 0;
  int n_pass = 0;
  int n_starts = 0;
  int n_results = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int fixed_lat = 0;
  int start_cyc = 0;
  logic stuck_next = 1'b0;

  res_t exp_q[$];
  op_t  op_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: bound expired, required event never seen", name);
  endtask

  // Divider reference: |a| scaled by 2^Q over |b|; returns {overflow, magnitude}.
  function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, m;
    logic [63:0] mv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = (sa < 0) ? -sa : sa;
    ub = (sb < 0) ? -sb : sb;
    if (ub == 0) return 33'h1_0000_0000;
    m = (ua <<< Q) / ub;
    mv = m;
    return {mv > 64'h7FFF_FFFF, mv[31:0]};
  endfunction

  function automatic res_t ref_result(input logic [31:0] a, input logic [31:0] b,
                                      input logic bi, input logic to);
    res_t r;
    logic s;
    logic [32:0] d;
    s = a[31] ^ b[31] ^ bi;
    if (b[30:0] == 31'd0) begin
      r.q = s ? 32'h8000_0001 : 32'h7FFF_FFFF; r.ovf = 1'b1; r.div0 = 1'b1; r.to = 1'b0;
    end else if (to) begin
      r.q = 32'd0; r.ovf = 1'b1; r.div0 = 1'b0; r.to = 1'b1;
    end else begin
      d = div_model(a, b);
      r.q = s ? 32'(~d[31:0] + 32'd1) : d[31:0];
      r.ovf = d[32]; r.div0 = 1'b0; r.to = 1'b0;
    end
    return r;
  endfunction

  // Divider stub: magnitude registered at completion, sign combinational on current operands.
  logic [31:0] stub_mag = '0;
  logic        stub_ovf = 1'b0;
  assign i_div_quotient = (o_div_dividend[31] ^ o_div_divisor[31] ^ o_div_both_image)
                          ? 32'(~stub_mag + 32'd1) : stub_mag;
  assign i_div_overflow = stub_ovf;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial begin : stub
    op_t cur;
    logic busy, stuck;
    int age, lat;
    logic [32:0] d;
    busy = 1'b0; stuck = 1'b0; age = 0; lat = 1;
    cur = '{32'd0, 32'd0, 1'b0, 1'b0};
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        busy = 1'b0; i_div_complete = 1'b0; stub_mag = '0; stub_ovf = 1'b0;
      end else if (o_div_start) begin
        n_starts++;
        start_cyc = cyc;
        if (op_q.size() == 0) begin
          fail("unexpected_start");
          cur = '{o_div_dividend, o_div_divisor, o_div_both_image, 1'b1};
        end else begin
          cur = op_q.pop_front();
          check("start_operands", {o_div_dividend, o_div_divisor, o_div_both_image},
                {cur.a, cur.b, cur.bi});
        end
        busy = 1'b1; age = 0; stuck = cur.to;
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
      end else if (busy) begin
        age++;
        if (age == 2) i_div_complete = 1'b0;
        if (!stuck && age == 2 + lat) begin
          check("operands_stable", {o_div_dividend, o_div_divisor, o_div_both_image},
                {cur.a, cur.b, cur.bi});
          d = div_model(o_div_dividend, o_div_divisor);
          stub_mag = d[31:0]; stub_ovf = d[32];
          i_div_complete = 1'b1;
          busy = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(posedge i_clk);
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'b0;
      2: m_ready = !m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: records accepted pushes, compares delivered results in order, checks hold stability.
  initial begin : monitor
    res_t r;
    logic hold_pending;
    logic [34:0] held;
    hold_pending = 1'b0; held = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        hold_pending = 1'b0;
      end else begin
        if (s_valid && s_ready) begin
          exp_q.push_back(ref_result(s_dividend, s_divisor, s_both_image, stuck_next));
          if (s_divisor[30:0] != 31'd0)
            op_q.push_back('{s_dividend, s_divisor, s_both_image, stuck_next});
        end
        if (hold_pending)
          check("hold_stable", {m_valid, m_quotient, m_overflow, m_div0, m_timeout}, {1'b1, held});
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) fail("unexpected_result");
          else begin
            r = exp_q.pop_front();
            check($sformatf("result%0d", n_results), {m_quotient, m_overflow, m_div0, m_timeout},
                  {r.q, r.ovf, r.div0, r.to});
          end
          n_results++;
        end
        hold_pending = m_valid && !m_ready;
        held = {m_quotient, m_overflow, m_div0, m_timeout};
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic bi);
    int guard;
    guard = 0;
    s_dividend = a; s_divisor = b; s_both_image = bi; s_valid = 1'b1;
    forever begin
      @(negedge i_clk);
      if (s_ready) begin
        @(posedge i_clk);
        #1;
        break;
      end
      guard++;
      if (guard > 2000) begin
        fail("push_accept");
        @(posedge i_clk);
        #1;
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound, input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge i_clk);
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail(name);
  endtask

  task automatic wait_drain(input int bound, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail(name);
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_s_ready"}, s_ready, 1'b1);
    check({name, "_outputs"},
          {o_div_start, o_div_dividend, o_div_divisor, o_div_both_image,
           m_valid, m_quotient, m_overflow, m_div0, m_timeout}, '0);
  endtask

  initial begin : hang_guard
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "hang");
  end

  vec_t vecs[7];

  initial begin
    logic ok;
    int s0, r0, lat;
    logic [31:0] a, b;

    vecs[0] = '{32'h0003_0000, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0, 1'b0, 1};
    vecs[1] = '{32'hFFFD_0000, 32'h0001_0000, 1'b0, 32'hFFFE_8000, 1'b0, 1'b0, 1};
    vecs[2] = '{32'hFFFD_0000, 32'h0001_0000, 1'b1, 32'h0001_8000, 1'b0, 1'b0, 1};
    vecs[3] = '{32'h0003_0000, 32'h0000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0};
    vecs[4] = '{32'hFFFD_0000, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0};
    vecs[5] = '{32'hFFFD_0000, 32'h8000_0000, 1'b1, 32'h8000_0001, 1'b1, 1'b1, 0};
    vecs[6] = '{32'h0003_0000, 32'h8000_0000, 1'b0, 32'h8000_0001, 1'b1, 1'b1, 0};

    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed vectors, one at a time with the output always ready.
    rdy_mode = 0;
    foreach (vecs[i]) begin
      s0 = n_starts;
      push(vecs[i].a, vecs[i].b, vecs[i].bi);
      wait_valid(200, $sformatf("vec%0d_valid", i), ok);
      if (ok)
        check($sformatf("vec%0d_result", i), {m_quotient, m_overflow, m_div0, m_timeout},
              {vecs[i].q, vecs[i].ovf, vecs[i].div0, 1'b0});
      check($sformatf("vec%0d_starts", i), n_starts - s0, vecs[i].starts);
      @(posedge i_clk);
      #1;
    end

    // Watchdog: stuck divider, then a normal op queued behind it.
    stuck_next = 1'b1;
    push(32'h0003_0000, 32'h0001_0000, 1'b0);
    stuck_next = 1'b0;
    push(32'h0004_0000, 32'h0001_0000, 1'b0);
    wait_valid(300, "timeout_valid", ok);
    if (ok) begin
      check("timeout_result", {m_quotient, m_overflow, m_div0, m_timeout}, {32'd0, 3'b101});
      lat = cyc - start_cyc;
      check("timeout_latency", (lat >= TO_CYC && lat <= TO_CYC + 6), 1'b1);
    end
    @(posedge i_clk);
    #1;
    wait_valid(100, "after_timeout_valid", ok);
    if (ok)
      check("after_timeout_result", {m_quotient, m_overflow, m_div0, m_timeout},
            {32'h0002_0000, 3'b000});
    wait_drain(200, "timeout_drain");

    // Backpressure: five back-to-back pushes with the output blocked.
    fixed_lat = 6;
    rdy_mode = 1;
    repeat (2) @(posedge i_clk);
    #1;
    r0 = n_results;
    for (int i = 0; i < 5; i++)
      push(32'(i + 1) << 17, 32'h0000_8000 + 32'(i) * 32'h1000, 1'(i));
    @(negedge i_clk);
    check("fifo_full_s_ready", s_ready, 1'b0);
    repeat (12) @(negedge i_clk);
    check("blocked_result_held", m_valid, 1'b1);
    @(posedge i_clk);
    #1;
    rdy_mode = 2;
    wait_drain(2000, "toggle_drain");
    check("toggle_result_count", n_results - r0, 5);

    // Random operands, gaps, backpressure and latencies against the reference model.
    fixed_lat = 0;
    rdy_mode = 3;
    r0 = n_results;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? {1'($urandom_range(0, 1)), 31'd0} : $urandom;
      stuck_next = ($urandom_range(0, 19) == 0);
      push(a, b, 1'($urandom_range(0, 1)));
      stuck_next = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge i_clk);
      #1;
    end
    wait_drain(20000, "random_drain");
    check("random_result_count", n_results - r0, 60);

    // Asynchronous reset while waiting on the divider, with another op queued.
    rdy_mode = 0;
    fixed_lat = 4;
    repeat (2) @(posedge i_clk);
    #1;
    stuck_next = 1'b1;
    push(32'h0003_0000, 32'h0001_0000, 1'b0);
    stuck_next = 1'b0;
    push(32'h0005_0000, 32'h0001_0000, 1'b1);
    repeat (8) @(posedge i_clk);
    #2;
    i_rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    op_q.delete();
    repeat (3) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    s0 = n_starts;
    repeat (10) @(negedge i_clk);
    check("post_reset_idle", {m_valid, s_ready, 32'(n_starts - s0)}, {1'b0, 1'b1, 32'd0});
    @(posedge i_clk);
    #1;
    push(32'h0003_0000, 32'h0001_0000, 1'b0);
    wait_valid(200, "post_reset_valid", ok);
    if (ok)
      check("post_reset_result", {m_quotient, m_overflow, m_div0, m_timeout},
            {32'h0001_8000, 3'b000});
    wait_drain(200, "post_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_sign_ctrl.md
Name: div_sign_ctrl

Overview:
- Front-end sequencer for the signed fixed-point divider `div_sign` (sign bit N-1, negative values two's-complement in N-1 bits, Q fractional bits).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one `start` pulse per operation, holds operands stable, and captures the quotient/overflow when the divider completes.
- Presents results on a valid/ready output stream; divide-by-zero is resolved locally and never reaches the divider.

Parameters:
- Q, 15, fractional bits (passed through to divider; informational here)
- N, 32, operand/quotient width including sign bit
- DEPTH, 4, operand FIFO depth (power of two, >=2)
- TO_CYC, 64, watchdog limit in cycles waiting for divider completion

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- s_valid  in  1  operand pair valid
- s_ready  out  1  FIFO not full
- s_dividend  in  N  dividend
- s_divisor  in  N  divisor
- s_both_image  in  1  operand pair is imaginary/imaginary (sign flip in divider)
- o_div_start  out  1  one-cycle start pulse to divider
- o_div_dividend  out  N  divider dividend, registered
- o_div_divisor  out  N  divider divisor, registered
- o_div_both_image  out  1  divider both_image, registered
- i_div_complete  in  1  divider completion level
- i_div_quotient  in  N  divider signed quotient
- i_div_overflow  in  1  divider overflow
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- m_quotient  out  N  result quotient
- m_overflow  out  1  divider overflow, or div0, or timeout
- m_div0  out  1  divisor magnitude was zero
- m_timeout  out  1  watchdog expired

Behaviour:
- Reset (async, `i_rstn`=0): FIFO empty, state IDLE, `s_ready`=1, and all other outputs 0 (`o_div_*`, `m_*`, watchdog count).
- Reset mid-operation discards everything; the divider shares `i_rstn`.
- FIFO
  - Push on `s_valid & s_ready`; pop when the controller loads the head.
  - Simultaneous push and pop allowed when full (`s_ready` stays 0 while full; push ignored). Pointers wrap mod DEPTH.
- Slot free = `!m_valid | m_ready`.
- FSM states: IDLE, START, ARM, WAIT.
- IDLE
  - If FIFO non-empty, pop the head into the `o_div_*` registers.
  - If divisor bits[N-2:0]==0 and slot free: write the output directly and stay in IDLE. No start pulse.
    - `m_quotient` = sign s = dividend[N-1]^divisor[N-1]^both_image.
    - s=0 gives {0, all ones}; s=1 gives {1, 0..01}.
    - `m_overflow`=1, `m_div0`=1.
  - A zero divisor with slot occupied is not popped until the slot is free.
  - Otherwise go to START.
- START: `o_div_start`=1 for exactly this cycle; next state ARM; watchdog cleared.
- ARM: ignore `i_div_complete` (may be stale high from the previous op); go to WAIT.
- WAIT
  - Watchdog increments each cycle.
  - When `i_div_complete`=1 and slot free: capture `i_div_quotient`/`i_div_overflow` into `m_quotient`/`m_overflow`, set `m_div0`=0, `m_timeout`=0, `m_valid`=1, then go to IDLE.
  - While the slot is occupied, stay in WAIT; the divider holds its result. The watchdog is frozen once complete=1.
  - If the watchdog reaches TO_CYC without complete: when slot free, output quotient 0, `m_overflow`=1, `m_timeout`=1, then IDLE.
- `o_div_*` operands must stay stable from pop until capture, because the divider's output sign is combinational on its current inputs.
- Output: `m_valid` clears on `m_ready` unless a new result is written the same cycle. `m_*` are stable while `m_valid & !m_ready`.
- Throughput: one result per divider latency + 3 cycles. Next pop may occur in the IDLE cycle after capture.

Test Plan:
- N=32, Q=15, `m_ready`=1: push 0x00030000 / 0x00010000, both_image=0 -> one start pulse; `m_quotient`=0x00018000 (3.0), overflow=0, div0=0.
- Push 0xFFFD0000 / 0x00010000 (-6/2) -> `m_quotient`=0xFFFE8000; the same pair with both_image=1 -> 0x00018000.
- Push 0x00030000 / 0x00000000 -> no `o_div_start`; next cycle `m_quotient`=0x7FFFFFFF, overflow=1, div0=1. Push 0xFFFD0000 / 0x80000000 -> 0x00000001? No: sign 1^1=0 gives 0x7FFFFFFF; with both_image=1 gives 0x80000001.
- Push 5 pairs back-to-back with DEPTH=4, `m_ready`=0 -> `s_ready` drops after the 4th accepted push plus one popped. Results emerge in order with no loss as `m_ready` toggles 1/0 each cycle.
- Tie `i_div_complete`=0 -> after 64 cycles in WAIT, result 0 with overflow=1, timeout=1; the next queued op then starts normally.
- Assert `i_rstn`=0 during WAIT -> all outputs 0 immediately. After release, `s_ready`=1 and FIFO empty; a new op completes correctly.
